// File: rtl/artyz7_button_debounce.sv
// Per-channel push-button conditioner: two-flop synchronizer, debounce counter, press/release pulses.
// Optional long-press detection is built when ARTYZ7_BUTTON_LONG_PRESS_EN is defined.
module artyz7_button_debounce #(
  parameter int num_buttons       = 4,
  parameter int stable_cycles     = 125000,
  parameter int long_press_cycles = 125000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [num_buttons-1:0] button_raw,
  output logic [num_buttons-1:0] button_level,
  output logic [num_buttons-1:0] button_press,
  output logic [num_buttons-1:0] button_release,
  output logic [num_buttons-1:0] long_press
);

  localparam int cnt_w = (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(stable_cycles - 1);

  if (stable_cycles < 1) begin : g_bad_stable
    $error("artyz7_button_debounce: stable_cycles must be >= 1");
  end

`ifdef ARTYZ7_BUTTON_LONG_PRESS_EN
  localparam int lp_w = (long_press_cycles > 0) ? $clog2(long_press_cycles + 1) : 1;
  localparam logic [lp_w-1:0] lp_target    = lp_w'(long_press_cycles);
  localparam logic [lp_w-1:0] lp_pre_target = lp_w'(long_press_cycles - 1);

  if (long_press_cycles < 1) begin : g_bad_long
    $error("artyz7_button_debounce: long_press_cycles must be >= 1");
  end
`else
  // long_press_cycles has no effect in this build; the port is tied low below.
  if (long_press_cycles == 0) begin : g_long_press_unused
  end
`endif

  for (genvar i = 0; i < num_buttons; i++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic [cnt_w-1:0] count;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // A pending acceptance is held off for one cycle after any pulse so a channel never pulses twice in a row.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        count     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1     <= button_raw[i];
        sync2     <= sync1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sync2 == level_q) begin
          count <= '0;
        end else if (count == cnt_last) begin
          if (!(press_q || release_q)) begin
            level_q   <= sync2;
            count     <= '0;
            press_q   <= sync2;
            release_q <= ~sync2;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end

    assign button_level[i]   = level_q;
    assign button_press[i]   = press_q;
    assign button_release[i] = release_q;

`ifdef ARTYZ7_BUTTON_LONG_PRESS_EN
    logic [lp_w-1:0] lp_count;
    logic            lp_q;

    // Counts held-cycles of the debounced level, saturating; fires once as the count reaches the target.
    always_ff @(posedge clk) begin
      if (reset || !level_q) begin
        lp_count <= '0;
        lp_q     <= 1'b0;
      end else begin
        lp_q <= (lp_count == lp_pre_target);
        if (lp_count != lp_target) begin
          lp_count <= lp_count + 1'b1;
        end
      end
    end

    assign long_press[i] = lp_q;
`else
    assign long_press[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_artyz7_button_debounce.sv
// Directed testbench for artyz7_button_debounce with num_buttons=4, stable_cycles=4, long_press_cycles=10.
// Long-press expectations follow ARTYZ7_BUTTON_LONG_PRESS_EN in the same build.
module tb_artyz7_button_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button_raw = 4'b0000;
  logic [3:0] button_level;
  logic [3:0] button_press;
  logic [3:0] button_release;
  logic [3:0] long_press;

  int vectors = 0;
  int miscompares = 0;

`ifdef ARTYZ7_BUTTON_LONG_PRESS_EN
  localparam logic [3:0] lp_ch2 = 4'b0100;
`else
  localparam logic [3:0] lp_ch2 = 4'b0000;
`endif

  artyz7_button_debounce #(
    .num_buttons(4),
    .stable_cycles(4),
    .long_press_cycles(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .button_level(button_level),
    .button_press(button_press),
    .button_release(button_release),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Drives the inputs for the next edge, then waits until just after that edge.
  task automatic applyStimulus(input logic [3:0] raw, input logic rst = 1'b0);
    button_raw = raw;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got lvl/prs/rel/lng=%b_%b_%b_%b want %b_%b_%b_%b", tag,
               observed[15:12], observed[11:8], observed[7:4], observed[3:0],
               expected[15:12], expected[11:8], expected[7:4], expected[3:0]);
    end
  endtask

  task automatic expectOutputs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                               input logic [3:0] rel, input logic [3:0] lng);
    checkOutput(tag, {button_level, button_press, button_release, long_press}, {lvl, prs, rel, lng});
  endtask

  initial begin
    // Reset hold, then quiet inputs
    repeat (2) begin
      applyStimulus(4'b0000, 1'b1);
      expectOutputs("reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0000);
      expectOutputs("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Channel 0 press: accepted on the 6th edge after the input change
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001);
      expectOutputs("ch0_press_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0001);
    expectOutputs("ch0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(4'b0001);
    expectOutputs("ch0_press_end", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

    // Channel 1 bounce: three highs, one low, then held high
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0011);
      expectOutputs("ch1_bounce_hi", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0001);
    expectOutputs("ch1_bounce_lo", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011);
      expectOutputs("ch1_settle_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0011);
    expectOutputs("ch1_press", 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0011);
      expectOutputs("ch1_press_once", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    end

    // Channel 0 release
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010);
      expectOutputs("ch0_release_wait", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0010);
    expectOutputs("ch0_release", 4'b0010, 4'b0000, 4'b0001, 4'b0000);
    applyStimulus(4'b0010);
    expectOutputs("ch0_release_end", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // Channel 2 held: long press 10 edges after the press pulse, once only
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0110);
      expectOutputs("ch2_press_wait", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0110);
    expectOutputs("ch2_press", 4'b0110, 4'b0100, 4'b0000, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0110);
      expectOutputs("ch2_long_wait", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0110);
    expectOutputs("ch2_long_press", 4'b0110, 4'b0000, 4'b0000, lp_ch2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0110);
      expectOutputs("ch2_long_once", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010);
      expectOutputs("ch2_release_wait", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0010);
    expectOutputs("ch2_release", 4'b0010, 4'b0000, 4'b0100, 4'b0000);

    // Channel 2 re-press, released after 9 held cycles: no long press
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0110);
      expectOutputs("ch2_repress_wait", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0110);
    expectOutputs("ch2_repress", 4'b0110, 4'b0100, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0110);
      expectOutputs("ch2_short_hold", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010);
      expectOutputs("ch2_short_rel_wait", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0010);
    expectOutputs("ch2_short_release", 4'b0010, 4'b0000, 4'b0100, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0010);
      expectOutputs("ch2_no_long", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    end

    // Reset two edges before a pending channel 3 acceptance
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1010);
      expectOutputs("ch3_pending", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b1010, 1'b1);
    expectOutputs("mid_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1010);
      expectOutputs("post_reset_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b1010);
    expectOutputs("post_reset_press", 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    applyStimulus(4'b1010);
    expectOutputs("post_reset_end", 4'b1010, 4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
